// File: rtl/fp_store_sequencer.sv
`timescale 1ns/1ps
// FP store sequencer: reads an FP register (pair) and writes one or two words to data memory.
// Latency: accept->done 4 cycles single / 5 double with memory ready; one store in flight.
// Backpressure: beats hold addr/data under mem_wr_ready=0; req_ready only in IDLE.
// Optional FP_STORE_ALIGN_CHECK_EN: reject misaligned addresses and odd-fs doubles with err.
module fp_store_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int WORD_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dbl,
  input  logic [4:0]        req_fs,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rf_rd_en,
  output logic [4:0]        rf_rd_idx,
  input  logic [63:0]       rf_rd_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_W0   = 3'd3,
    S_W1   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                dbl_q, dbl_d;
  logic [4:0]          fs_q, fs_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                bad_req;

`ifdef FP_STORE_ALIGN_CHECK_EN
  assign bad_req = (req_addr[1:0] != 2'b00) || (req_dbl && req_fs[0]);
`else
  assign bad_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dbl_q   <= 1'b0;
      fs_q    <= 5'd0;
      addr_q  <= '0;
      hold_q  <= 64'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dbl_q   <= dbl_d;
      fs_q    <= fs_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dbl_d   = dbl_q;
    fs_d    = fs_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (bad_req) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            dbl_d   = req_dbl;
            fs_d    = req_fs;
            // Word-align; with the check enabled accepted addresses are already aligned.
            addr_d  = req_addr & ~ADDR_W'(3);
            state_d = S_RD;
          end
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        hold_d  = rf_rd_data;
        state_d = S_W0;
      end
      S_W0: begin
        if (mem_wr_ready) begin
          if (dbl_q) begin
            state_d = S_W1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_W1: begin
        if (mem_wr_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops mem_wr_valid at once.
  always_comb begin
    req_ready    = (state_q == S_IDLE);
    rf_rd_en     = (state_q == S_RD);
    rf_rd_idx    = fs_q;
    mem_wr_valid = (state_q == S_W0) || (state_q == S_W1);
    mem_wr_addr  = (state_q == S_W1) ? addr_q + ADDR_W'(WORD_STEP) : addr_q;
    mem_wr_data  = (state_q == S_W1) ? hold_q[31:0] : hold_q[63:32];
    done         = done_q;
`ifdef FP_STORE_ALIGN_CHECK_EN
    err          = err_q;
`else
    err          = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fp_store_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for fp_store_sequencer: expected beats queued at issue, popped on accept.
module tb_fp_store_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_dbl = 1'b0;
  logic [4:0]  req_fs = 5'd0;
  logic [31:0] req_addr = 32'd0;
  logic        rf_rd_en;
  logic [4:0]  rf_rd_idx;
  logic [63:0] rf_rd_data = 64'd0;
  logic        mem_wr_valid;
  logic        mem_wr_ready = 1'b1;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  fp_store_sequencer #(.ADDR_W(32), .WORD_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dbl(req_dbl),
    .req_fs(req_fs), .req_addr(req_addr),
    .rf_rd_en(rf_rd_en), .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .done(done), .err(err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       exp_b;
  logic [31:0] F [32];
  logic [4:0]  nxt_idx;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          rd_cnt = 0;
  int          vld_cnt = 0;
  logic [4:0]  last_idx = 5'd0;
  logic        bp_mode = 1'b0;
  int          bp_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] st_addr, st_data;

  // Register-file model: registered read, garbage whenever not strobed.
  assign nxt_idx = rf_rd_idx + 5'd1;
  always @(posedge clk)
    rf_rd_data <= rf_rd_en ? {F[rf_rd_idx], F[nxt_idx]} : {$urandom, $urandom};

  // Memory ready driver: in backpressure mode each beat waits 3 low cycles.
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      if (mem_wr_valid) begin
        if (bp_cnt < 3) begin
          mem_wr_ready = 1'b0;
          bp_cnt++;
        end else begin
          mem_wr_ready = 1'b1;
          bp_cnt = 0;
        end
      end else begin
        mem_wr_ready = 1'b0;
        bp_cnt = 0;
      end
    end else begin
      mem_wr_ready = 1'b1;
      bp_cnt = 0;
    end
  end

  // Monitor: scoreboard pop on accepted beats, stability under stall.
  always @(negedge clk) begin
    if (rf_rd_en) begin
      rd_cnt++;
      last_idx = rf_rd_idx;
    end
    if (mem_wr_valid) vld_cnt++;
    if (stall_prev && rst_n) begin
      n_cmp++;
      if (!mem_wr_valid || mem_wr_addr !== st_addr || mem_wr_data !== st_data) begin
        n_fail++;
        $display("FAIL hold_stable: got v=%b a=%h d=%h, want v=1 a=%h d=%h",
                 mem_wr_valid, mem_wr_addr, mem_wr_data, st_addr, st_data);
      end
    end
    if (mem_wr_valid && mem_wr_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got a=%h d=%h, want no beat", mem_wr_addr, mem_wr_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (mem_wr_addr !== exp_b.addr || mem_wr_data !== exp_b.data) begin
          n_fail++;
          $display("FAIL beat: got a=%h d=%h, want a=%h d=%h",
                   mem_wr_addr, mem_wr_data, exp_b.addr, exp_b.data);
        end
      end
      stall_prev = 1'b0;
    end else if (mem_wr_valid) begin
      stall_prev = 1'b1;
      st_addr = mem_wr_addr;
      st_data = mem_wr_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic issue(input logic dbl, input logic [4:0] fs, input logic [31:0] addr);
    req_valid = 1'b1;
    req_dbl   = dbl;
    req_fs    = fs;
    req_addr  = addr;
  endtask

  // Counts cycles from the accept edge to done; scrambles req_* after accept; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        req_fs    = 5'($urandom);
        req_addr  = $urandom;
        req_dbl   = 1'($urandom);
      end
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mem_wr_valid, rf_rd_en, done, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 0000", {mem_wr_valid, rf_rd_en, done, err});
    end
    n_cmp++;
    if ({rf_rd_idx, mem_wr_addr, mem_wr_data} !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_data: got idx=%h a=%h d=%h, want 0", rf_rd_idx, mem_wr_addr, mem_wr_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, want 1", req_ready);
    end
  endtask

  task automatic test_single;
    int cyc, rd0, v0;
    F[4] = 32'h3F80_0000;
    exp_q.push_back({32'h0000_0100, 32'h3F80_0000});
    rd0 = rd_cnt; v0 = vld_cnt;
    issue(1'b0, 5'd4, 32'h100);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4) begin n_fail++; $display("FAIL single_latency: got %0d, want 4", cyc); end
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b, want 0", err); end
    n_cmp++;
    if (rd_cnt - rd0 !== 1 || last_idx !== 5'd4) begin
      n_fail++; $display("FAIL single_read: got n=%0d idx=%0d, want n=1 idx=4", rd_cnt - rd0, last_idx);
    end
    n_cmp++;
    if (vld_cnt - v0 !== 1 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL single_beats: got vcyc=%0d left=%0d, want 1/0", vld_cnt - v0, exp_q.size());
    end
  endtask

  task automatic test_double;
    int cyc, rd0;
    F[2] = 32'h4009_21FB; F[3] = 32'h5444_2D18;
    exp_q.push_back({32'h0000_0200, 32'h4009_21FB});
    exp_q.push_back({32'h0000_0204, 32'h5444_2D18});
    rd0 = rd_cnt;
    issue(1'b1, 5'd2, 32'h200);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 5) begin n_fail++; $display("FAIL double_latency: got %0d, want 5", cyc); end
    n_cmp++;
    if (rd_cnt - rd0 !== 1 || last_idx !== 5'd2) begin
      n_fail++; $display("FAIL double_read: got n=%0d idx=%0d, want n=1 idx=2", rd_cnt - rd0, last_idx);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL double_left: got %0d, want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure;
    int cyc, v0;
    bp_mode = 1'b1;
    exp_q.push_back({32'h0000_0400, 32'h4009_21FB});
    exp_q.push_back({32'h0000_0404, 32'h5444_2D18});
    v0 = vld_cnt;
    issue(1'b1, 5'd2, 32'h400);
    wait_done(cyc);
    bp_mode = 1'b0;
    n_cmp++;
    if (cyc !== 11) begin n_fail++; $display("FAIL bp_latency: got %0d, want 11", cyc); end
    n_cmp++;
    if (vld_cnt - v0 !== 8) begin n_fail++; $display("FAIL bp_valid_cycles: got %0d, want 8", vld_cnt - v0); end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL bp_left: got %0d, want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    int c1, c2, rd0;
    F[6] = 32'hDEAD_BEEF; F[7] = 32'h1234_5678;
    exp_q.push_back({32'h0000_0300, 32'hDEAD_BEEF});
    exp_q.push_back({32'h0000_0304, 32'h1234_5678});
    rd0 = rd_cnt;
    issue(1'b0, 5'd6, 32'h300);
    wait_done(c1);
    n_cmp++;
    if (c1 !== 4 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got cyc=%0d ready=%b, want 4/1", c1, req_ready);
    end
    issue(1'b0, 5'd7, 32'h304);
    wait_done(c2);
    n_cmp++;
    if (c2 !== 4) begin n_fail++; $display("FAIL b2b_second: got %0d, want 4", c2); end
    n_cmp++;
    if (rd_cnt - rd0 !== 2 || last_idx !== 5'd7 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL b2b_reads: got n=%0d idx=%0d left=%0d, want 2/7/0", rd_cnt - rd0, last_idx, exp_q.size());
    end
  endtask

  task automatic test_addr_wrap;
    int cyc;
    F[30] = 32'hA5A5_0030; F[31] = 32'h5A5A_0031;
    exp_q.push_back({32'hFFFF_FFFC, 32'hA5A5_0030});
    exp_q.push_back({32'h0000_0000, 32'h5A5A_0031});
    issue(1'b1, 5'd30, 32'hFFFF_FFFC);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 5 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL addr_wrap: got cyc=%0d left=%0d, want 5/0", cyc, exp_q.size());
    end
  endtask

  task automatic test_fs31;
    int cyc, rd0;
    F[31] = 32'h7777_0031; F[0] = 32'h8888_0000;
    rd0 = rd_cnt;
`ifndef FP_STORE_ALIGN_CHECK_EN
    exp_q.push_back({32'h0000_0500, 32'h7777_0031});
    exp_q.push_back({32'h0000_0504, 32'h8888_0000});
`endif
    issue(1'b1, 5'd31, 32'h500);
    wait_done(cyc);
`ifdef FP_STORE_ALIGN_CHECK_EN
    n_cmp++;
    if (cyc !== 1 || err !== 1'b1 || rd_cnt !== rd0) begin
      n_fail++; $display("FAIL fs31_reject: got cyc=%0d err=%b reads=%0d, want 1/1/0", cyc, err, rd_cnt - rd0);
    end
`else
    n_cmp++;
    if (cyc !== 5 || err !== 1'b0 || rd_cnt - rd0 !== 1) begin
      n_fail++; $display("FAIL fs31_wrap: got cyc=%0d err=%b reads=%0d, want 5/0/1", cyc, err, rd_cnt - rd0);
    end
`endif
    n_cmp++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL fs31_left: got %0d, want 0", exp_q.size()); end
  endtask

  task automatic test_align;
    int cyc, rd0, v0;
    rd0 = rd_cnt; v0 = vld_cnt;
`ifndef FP_STORE_ALIGN_CHECK_EN
    exp_q.push_back({32'h0000_0100, 32'h3F80_0000});
`endif
    issue(1'b0, 5'd4, 32'h102);
    wait_done(cyc);
`ifdef FP_STORE_ALIGN_CHECK_EN
    n_cmp++;
    if (cyc !== 1 || err !== 1'b1) begin
      n_fail++; $display("FAIL align_reject: got cyc=%0d err=%b, want 1/1", cyc, err);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rd_cnt !== rd0 || vld_cnt !== v0) begin
      n_fail++; $display("FAIL align_quiet: got reads=%0d vcyc=%0d, want 0/0", rd_cnt - rd0, vld_cnt - v0);
    end
`else
    n_cmp++;
    if (cyc !== 4 || err !== 1'b0) begin
      n_fail++; $display("FAIL align_masked: got cyc=%0d err=%b, want 4/0", cyc, err);
    end
`endif
    n_cmp++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL align_left: got %0d, want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    F[8] = 32'h0BAD_F00D; F[9] = 32'hCAFE_0009;
    exp_q.push_back({32'h0000_0600, 32'h0BAD_F00D});
    bp_mode = 1'b1;
    issue(1'b1, 5'd8, 32'h600);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
    end
    n_cmp++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h604) begin
      n_fail++; $display("FAIL mid_w1: got v=%b a=%h, want 1/00000604", mem_wr_valid, mem_wr_addr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_wr_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: got v=%b done=%b, want 0/0", mem_wr_valid, done);
    end
    bp_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || mem_wr_valid || rf_rd_en) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_after: got activity=%b ready=%b, want 0/1", seen, req_ready);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL mid_left: got %0d, want 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) F[i] = 32'h1000_0000 + i;
    test_reset;
    test_single;
    test_double;
    test_backpressure;
    test_back_to_back;
    test_addr_wrap;
    test_fs31;
    test_align;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
